// File: rtl/aes_enc_ctrl.sv
// Iterative AES encryption round controller: one round per clock through an
// external SubBytes/ShiftRows stage, the shared mixColumns block and AddRoundKey.
module aes_enc_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic [127:0] sr_in,
    input  logic [127:0] sr_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    localparam int         DATA_W   = 128;
    localparam logic [3:0] LAST_RND = 4'(NR);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

    fsm_t              fsm;
    logic [DATA_W-1:0] st;
    logic [3:0]        rnd;
    logic [DATA_W-1:0] mc_out;

    mixColumns u_mix (
        .state_in  (sr_out),
        .state_out (mc_out)
    );

    assign sr_in    = st;
    assign rk_idx   = (fsm == ROUND) ? rnd : 4'd0;
    assign out_data = out_valid ? st : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm       <= IDLE;
            st        <= '0;
            rnd       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        st       <= in_data ^ rk;
                        rnd      <= 4'd1;
                        fsm      <= ROUND;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ROUND: begin
                    // The last round skips MixColumns and hands the state to DONE.
                    if (rnd < LAST_RND) begin
                        st  <= mc_out ^ rk;
                        rnd <= rnd + 4'd1;
                    end else begin
                        st        <= sr_out ^ rk;
                        fsm       <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // in_ready only rises after the handoff edge, so no accept overlaps it.
                    if (out_ready) begin
                        fsm       <= IDLE;
                        rnd       <= '0;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    fsm       <= IDLE;
                    rnd       <= '0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// AES MixColumns over a column-major 128-bit state (bit 127 = row 0, column 0).
module mixColumns (
    input  logic [127:0] state_in,
    output logic [127:0] state_out
);
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = state_in[127-32*c -: 8];
        assign a1 = state_in[119-32*c -: 8];
        assign a2 = state_in[111-32*c -: 8];
        assign a3 = state_in[103-32*c -: 8];
        assign state_out[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        assign state_out[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        assign state_out[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        assign state_out[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
endmodule

// File: tb/tb_aes_enc_ctrl.sv
// Bench for aes_enc_ctrl: AES reference model, cycle model for the NR=10 instance,
// directed FIPS-197 vectors, back-pressure, busy rejection and mid-run reset.
`timescale 1ns/1ps
module tb_aes_enc_ctrl;
    localparam int NRA = 10;
    localparam int NRB = 14;

    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] KEY_256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] in_data, rk, sr_in, sr_out, out_data;
    logic [3:0]   rk_idx;

    logic         in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
    logic [127:0] in_data_b, rk_b, sr_in_b, sr_out_b, out_data_b;
    logic [3:0]   rk_idx_b;

    logic [127:0] rka [0:15];
    logic [127:0] rkb [0:15];
    logic [31:0]  ksw [0:63];

    int checks = 0;
    int failures = 0;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse (a^254) then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] mix_ref(input logic [127:0] s);
        logic [127:0] o = '0;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3);
            o[103-32*c -: 8] = gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2);
        end
        return o;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input int nr, input bit sel);
        logic [127:0] s;
        s = pt ^ (sel ? rkb[0] : rka[0]);
        for (int r = 1; r <= nr; r++) begin
            s = sub_shift(s);
            if (r != nr) s = mix_ref(s);
            s = s ^ (sel ? rkb[r] : rka[r]);
        end
        return s;
    endfunction

    task automatic expand(input logic [255:0] key, input int nk, input int nr, input bit sel);
        logic [7:0]  rc = 8'h01;
        logic [31:0] t;
        for (int i = 0; i < nk; i++) ksw[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = ksw[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            ksw[i] = ksw[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            if (sel) rkb[r] = (r <= nr) ? {ksw[4*r], ksw[4*r+1], ksw[4*r+2], ksw[4*r+3]} : '0;
            else     rka[r] = (r <= nr) ? {ksw[4*r], ksw[4*r+1], ksw[4*r+2], ksw[4*r+3]} : '0;
        end
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    assign rk       = rka[rk_idx];
    assign sr_out   = sub_shift(sr_in);
    assign rk_b     = rkb[rk_idx_b];
    assign sr_out_b = sub_shift(sr_in_b);

    aes_enc_ctrl #(.NR(NRA)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .rk_idx(rk_idx), .rk(rk), .sr_in(sr_in), .sr_out(sr_out), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    aes_enc_ctrl #(.NR(NRB)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .rk_idx(rk_idx_b), .rk(rk_b), .sr_in(sr_in_b), .sr_out(sr_out_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .out_data(out_data_b), .busy(busy_b)
    );

    // Transaction model for the NR=10 instance: rounds completed since accept (-1 = idle).
    int           m_cnt = -1;
    logic [127:0] m_res = '0;
    bit           cmp_en = 1'b0;
    bit           m_idle, m_done;
    logic [3:0]   m_rk;

    always @(posedge clk or posedge rst) begin
        if (rst) m_cnt = -1;
        else if (m_cnt < 0) begin
            if (in_valid) begin
                m_cnt = 0;
                m_res = aes_ref(in_data, NRA, 1'b0);
            end
        end else if (m_cnt < NRA) m_cnt = m_cnt + 1;
        else if (out_ready) m_cnt = -1;
    end

    always @(negedge clk) begin
        #1;
        if (cmp_en) begin
            m_idle = (m_cnt < 0);
            m_done = (m_cnt == NRA);
            m_rk   = (m_idle || m_done) ? 4'd0 : 4'(m_cnt + 1);
            chk("cyc_in_ready",  128'(in_ready),  128'(m_idle));
            chk("cyc_busy",      128'(busy),      128'(!m_idle));
            chk("cyc_out_valid", 128'(out_valid), 128'(m_done));
            chk("cyc_out_data",  out_data,        m_done ? m_res : 128'h0);
            chk("cyc_rk_idx",    128'(rk_idx),    128'(m_rk));
        end
    end

    // Called at a falling edge; returns at the falling edge after the output handoff.
    task automatic run_a(input logic [127:0] pt, input int hold, input logic [127:0] expv,
                         input string tag, input bit chk_seq, input bit keep,
                         input logic [127:0] pt2);
        int n, lat;
        logic [43:0] seq;
        in_data   = pt;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk({tag, "_accept"}, 128'(in_ready), 128'(1));
            in_valid = 1'b0;
            return;
        end
        seq = {40'h0, rk_idx};
        @(posedge clk);
        lat = 0;
        while (lat <= 40) begin
            @(negedge clk);
            if (lat == 0) begin
                if (keep) in_data = pt2;
                else in_valid = 1'b0;
            end
            if (out_valid) break;
            seq = {seq[39:0], rk_idx};
            @(posedge clk);
            lat++;
        end
        chk({tag, "_out_valid"}, 128'(out_valid), 128'(1));
        chk({tag, "_latency"}, 128'(lat), 128'(NRA));
        chk({tag, "_out_data"}, out_data, expv);
        if (chk_seq) chk({tag, "_rk_idx_seq"}, 128'(seq), 128'(44'h0123456789a));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_hold_valid"}, 128'(out_valid), 128'(1));
            chk({tag, "_hold_data"}, out_data, expv);
            chk({tag, "_hold_in_ready"}, 128'(in_ready), 128'(0));
            chk({tag, "_hold_busy"}, 128'(busy), 128'(1));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_valid_drop"}, 128'(out_valid), 128'(0));
        chk({tag, "_in_ready_rise"}, 128'(in_ready), 128'(1));
        chk({tag, "_busy_drop"}, 128'(busy), 128'(0));
        chk({tag, "_data_zero"}, out_data, 128'h0);
    endtask

    task automatic run_b(input logic [127:0] pt, input logic [127:0] expv);
        int n, lat;
        in_data_b  = pt;
        in_valid_b = 1'b1;
        n = 0;
        while (!in_ready_b && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        lat = 0;
        while (lat <= 40) begin
            @(negedge clk);
            in_valid_b = 1'b0;
            if (out_valid_b) break;
            @(posedge clk);
            lat++;
        end
        chk("nr14_out_valid", 128'(out_valid_b), 128'(1));
        chk("nr14_latency", 128'(lat), 128'(NRB));
        chk("nr14_out_data", out_data_b, expv);
        @(posedge clk);
        @(negedge clk);
        chk("nr14_valid_drop", 128'(out_valid_b), 128'(0));
        chk("nr14_in_ready", 128'(in_ready_b), 128'(1));
    endtask

    initial begin
        int n;
        rst = 1'b1;
        in_valid = 1'b0;   in_data = '0;   out_ready = 1'b1;
        in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b1;
        expand({KEY_B, 128'h0}, 4, NRA, 1'b0);
        expand(KEY_256, 8, NRB, 1'b1);

        @(negedge clk);
        #1;
        chk("rst_in_ready",  128'(in_ready),  128'(1));
        chk("rst_busy",      128'(busy),      128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data",  out_data,        128'h0);
        chk("rst_rk_idx",    128'(rk_idx),    128'(0));
        chk("rst_b_in_ready", 128'(in_ready_b), 128'(1));
        @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;

        chk("model_appB", aes_ref(PT_B, NRA, 1'b0), CT_B);
        chk("model_aes256", aes_ref(PT_C, NRB, 1'b1), CT_256);

        run_a(PT_B, 0, CT_B, "appB", 1'b0, 1'b0, '0);
        run_a(PT_B, 5, CT_B, "backpressure", 1'b0, 1'b0, '0);

        expand({KEY_C, 128'h0}, 4, NRA, 1'b0);
        chk("model_appC", aes_ref(PT_C, NRA, 1'b0), CT_C);
        run_a(PT_C, 0, CT_C, "appC", 1'b1, 1'b0, '0);

        run_a(PT_C, 0, CT_C, "busy_first", 1'b0, 1'b1, PT_B);
        run_a(PT_B, 0, aes_ref(PT_B, NRA, 1'b0), "busy_second", 1'b0, 1'b0, '0);

        expand({KEY_B, 128'h0}, 4, NRA, 1'b0);
        in_data = PT_C;
        in_valid = 1'b1;
        n = 0;
        while (!(busy && rk_idx == 4'd5) && n < 50) begin
            @(negedge clk);
            if (busy) in_valid = 1'b0;
            n++;
        end
        chk("midrst_reached_round5", 128'(rk_idx), 128'(5));
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 128'(out_valid), 128'(0));
        chk("midrst_out_data",  out_data,        128'h0);
        chk("midrst_busy",      128'(busy),      128'(0));
        chk("midrst_in_ready",  128'(in_ready),  128'(1));
        chk("midrst_rk_idx",    128'(rk_idx),    128'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_a(PT_B, 0, CT_B, "after_rst", 1'b0, 1'b0, '0);

        @(negedge clk);
        run_b(PT_C, CT_256);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
